board_store: RTL

- Owns the 6x6 card board: colour memory, selection bus and hidden bus.
- Serves the matcher's colour-read port (addr -> r/g/b) and applies the matcher's verdict (ms/mf) to board state.
- Accepts player picks from the cursor logic.
- Deals a new shuffled board (18 colour pairs) on request, using an LFSR-driven Fisher-Yates shuffle.

---
 rtl/board_pkg.sv | 38 +++
 rtl/board_store_if.sv | 30 +++
 rtl/board_lfsr.sv | 33 +++
 rtl/board_store.sv | 165 ++++++++++++++++
 4 files changed

// File: rtl/board_pkg.sv
// Shared board constants: geometry, colour format, palette and LFSR taps.
package board_pkg;

  localparam int unsigned NROWS    = 6;
  localparam int unsigned NCOLS    = 6;
  localparam int unsigned NCARDS   = NROWS * NCOLS;
  localparam int unsigned NCOLOURS = NCARDS / 2;

  // Fibonacci taps x^16 + x^14 + x^13 + x^11 -> state bits 15, 13, 12, 10.
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  typedef struct packed {
    logic [2:0] r;
    logic [2:0] g;
    logic [1:0] b;
  } rgb332_t;

  typedef enum logic [1:0] {
    StIdle,
    StFill,
    StShuffle,
    StFinish
  } deal_state_e;

  // Entry 0 sits in the least significant byte; the VGA renderer uses the same table.
  localparam logic [NCOLOURS*8-1:0] PALETTE_FLAT = {
    8'hA1, 8'h5A, 8'hC8, 8'h13, 8'h24, 8'hB6, 8'h49, 8'h8C, 8'h6D,
    8'hF0, 8'h92, 8'hFF, 8'h1F, 8'hE3, 8'hFC, 8'h03, 8'h1C, 8'hE0
  };

  function automatic rgb332_t palette(input logic [4:0] idx);
    if (int'(idx) >= int'(NCOLOURS)) begin
      return '0;
    end
    return rgb332_t'(PALETTE_FLAT[int'(idx)*8 +: 8]);
  endfunction

endpackage

// File: rtl/board_store_if.sv
// Board store bus: matcher read port and verdict, cursor picks, deal control.
interface board_store_if;
  import board_pkg::*;

  logic [5:0]        addr;
  logic [2:0]        r;
  logic [2:0]        g;
  logic [1:0]        b;
  logic [NCARDS-1:0] sel_bus;
  logic [NCARDS-1:0] hidden_bus;
  logic              ms;
  logic              mf;
  logic [5:0]        cursor;
  logic              pick;
  logic              new_game;
  logic [15:0]       seed;
  logic              busy;
  logic              cleared;

  modport master (
    output addr, ms, mf, cursor, pick, new_game, seed,
    input  r, g, b, sel_bus, hidden_bus, busy, cleared
  );

  modport slave (
    input  addr, ms, mf, cursor, pick, new_game, seed,
    output r, g, b, sel_bus, hidden_bus, busy, cleared
  );

endinterface

// File: rtl/board_lfsr.sv
// 16-bit Fibonacci LFSR driving the shuffle; a zero seed falls back to SEED_DEFAULT.
module board_lfsr
  import board_pkg::*;
#(
  parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic [15:0] i_seed,
  input  logic        i_step,
  output logic [15:0] o_state
);

  logic [15:0] r_state;
  logic        w_feedback;

  assign w_feedback = ^(r_state & LFSR_TAPS);

  // Load takes priority over step so a restarted deal begins from the new seed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= SEED_DEFAULT;
    end else if (i_load) begin
      r_state <= (i_seed == 16'd0) ? SEED_DEFAULT : i_seed;
    end else if (i_step) begin
      r_state <= {r_state[14:0], w_feedback};
    end
  end

  assign o_state = r_state;

endmodule

// File: rtl/board_store.sv
// 6x6 card board: colour memory with registered read port, selection/hidden state,
// matcher verdicts, player picks and the fill + Fisher-Yates deal sequencer.
module board_store
  import board_pkg::*;
#(
  parameter logic [15:0] SEED_DEFAULT = 16'hACE1
) (
  input logic          clk,
  input logic          rst,
  board_store_if.slave bus
);

  localparam logic [5:0] LAST_CELL = 6'(NCARDS - 1);

  deal_state_e       r_state, w_state_next;
  logic [5:0]        r_idx, w_idx_next;
  logic              w_fill, w_swap, w_finish, w_busy;
  logic [15:0]       w_lfsr;
  logic [21:0]       w_prod;
  logic [5:0]        w_j;
  rgb332_t           r_colour [NCARDS];
  rgb332_t           r_rgb;
  logic [NCARDS-1:0] r_sel, r_hidden;
  logic              r_playing, r_cleared;
  logic              w_pick_ok, w_can_set;

  board_lfsr #(
    .SEED_DEFAULT (SEED_DEFAULT)
  ) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .i_load  (bus.new_game),
    .i_seed  (bus.seed),
    .i_step  (w_swap),
    .o_state (w_lfsr)
  );

  // Deal sequencer state and working cell index.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_next;
      r_idx   <= w_idx_next;
    end
  end

  // Sequencer next state; new_game restarts from FILL whatever the current state.
  always_comb begin
    w_state_next = r_state;
    w_idx_next   = r_idx;
    w_fill       = 1'b0;
    w_swap       = 1'b0;
    w_finish     = 1'b0;
    if (bus.new_game) begin
      w_state_next = StFill;
      w_idx_next   = '0;
    end else begin
      unique case (r_state)
        StIdle: ;
        StFill: begin
          w_fill = 1'b1;
          if (r_idx == LAST_CELL) begin
            w_state_next = StShuffle;
            w_idx_next   = LAST_CELL;
          end else begin
            w_idx_next = r_idx + 6'd1;
          end
        end
        StShuffle: begin
          w_swap = 1'b1;
          if (r_idx == 6'd1) begin
            w_state_next = StFinish;
          end else begin
            w_idx_next = r_idx - 6'd1;
          end
        end
        StFinish: begin
          w_finish     = 1'b1;
          w_state_next = StIdle;
        end
        default: w_state_next = StIdle;
      endcase
    end
  end

  assign w_busy = (r_state != StIdle);

  // Swap partner: low LFSR byte scaled into 0..r_idx.
  assign w_prod = 22'(w_lfsr & 16'h00FF) * 22'(r_idx + 6'd1);
  assign w_j    = 6'(w_prod >> 8);

  // Colour memory: sequential palette fill, then in-place swaps.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < NCARDS; i++) begin
        r_colour[i] <= '0;
      end
    end else if (w_fill) begin
      r_colour[r_idx] <= palette(r_idx[5:1]);
    end else if (w_swap) begin
      r_colour[r_idx] <= r_colour[w_j];
      r_colour[w_j]   <= r_colour[r_idx];
    end
  end

  // Registered colour read port, served even while dealing.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rgb <= '0;
    end else begin
      r_rgb <= (bus.addr <= LAST_CELL) ? r_colour[bus.addr] : '0;
    end
  end

  // A pick only counts when nothing else is touching the selection this cycle.
  assign w_pick_ok = bus.pick && r_playing && !w_busy && !bus.ms && !bus.mf &&
                     (bus.cursor <= LAST_CELL) && !r_hidden[bus.cursor];
  assign w_can_set = ($countones(r_sel) < 2);

  // Selection, removal and completion state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sel     <= '0;
      r_hidden  <= '1;
      r_playing <= 1'b0;
      r_cleared <= 1'b0;
    end else begin
      r_cleared <= r_playing && (&r_hidden);
      if (bus.new_game) begin
        r_sel     <= '0;
        r_hidden  <= '1;
        r_playing <= 1'b0;
        r_cleared <= 1'b0;
      end else if (w_finish) begin
        r_sel     <= '0;
        r_hidden  <= '0;
        r_playing <= 1'b1;
      end else if (!w_busy) begin
        if (bus.ms) begin
          r_hidden <= r_hidden | r_sel;
          r_sel    <= '0;
        end else if (bus.mf) begin
          r_sel <= '0;
        end else if (w_pick_ok) begin
          if (r_sel[bus.cursor]) begin
            r_sel[bus.cursor] <= 1'b0;
          end else if (w_can_set) begin
            r_sel[bus.cursor] <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.r          = r_rgb.r;
  assign bus.g          = r_rgb.g;
  assign bus.b          = r_rgb.b;
  assign bus.sel_bus    = r_sel;
  assign bus.hidden_bus = r_hidden;
  assign bus.busy       = w_busy;
  assign bus.cleared    = r_cleared;

endmodule
